// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 11-bit frame clocked by the device,
// ACK check and watchdog. Both lines are driven open-drain through the *_oe outputs.
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int TIMEOUT_CYCLES = 750000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] tx_data,
   input  logic       tx_start,
   output logic       tx_busy,
   output logic       tx_done,
   output logic       tx_error,
   output logic [1:0] err_code,
   input  logic       ps2_clk_i,
   input  logic       ps2_data_i,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe
);

   localparam int MAX_CNT = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
   localparam int TW      = $clog2(MAX_CNT + 1);
   localparam logic [TW-1:0] INHIBIT_LAST = TW'(INHIBIT_CYCLES - 1);
   localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_IDLE} state_t;

   state_t        state, state_n;
   logic [1:0]    clk_sync, data_sync;
   logic          clk_dly;
   logic          fe;
   logic          wd_expired;
   logic [9:0]    shreg, shreg_n;
   logic [3:0]    bit_cnt, bit_cnt_n;
   logic [TW-1:0] timer, timer_n;
   logic          busy_n, done_n, error_n, clk_oe_n, data_oe_n;
   logic [1:0]    err_code_n;

   // NOTE: synchronisers reset to 1 (idle bus) so releasing reset cannot fake a falling edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clk_sync  <= 2'b11;
         data_sync <= 2'b11;
         clk_dly   <= 1'b1;
      end else begin
         clk_sync  <= {clk_sync[0], ps2_clk_i};
         data_sync <= {data_sync[0], ps2_data_i};
         clk_dly   <= clk_sync[1];
      end
   end

   assign fe         = clk_dly & ~clk_sync[1];
   assign wd_expired = (timer == TIMEOUT_LAST);

   // NOTE: all state and outputs use non-blocking assignments so every flop sees pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         shreg       <= '0;
         bit_cnt     <= '0;
         timer       <= '0;
         tx_busy     <= 1'b0;
         tx_done     <= 1'b0;
         tx_error    <= 1'b0;
         err_code    <= 2'b00;
         ps2_clk_oe  <= 1'b0;
         ps2_data_oe <= 1'b0;
      end else begin
         state       <= state_n;
         shreg       <= shreg_n;
         bit_cnt     <= bit_cnt_n;
         timer       <= timer_n;
         tx_busy     <= busy_n;
         tx_done     <= done_n;
         tx_error    <= error_n;
         err_code    <= err_code_n;
         ps2_clk_oe  <= clk_oe_n;
         ps2_data_oe <= data_oe_n;
      end
   end

   always_comb begin
      // NOTE: every variable gets a default first, so no path can infer a latch.
      state_n    = state;
      shreg_n    = shreg;
      bit_cnt_n  = bit_cnt;
      timer_n    = timer;
      busy_n     = tx_busy;
      done_n     = 1'b0;
      error_n    = 1'b0;
      err_code_n = err_code;
      clk_oe_n   = ps2_clk_oe;
      data_oe_n  = ps2_data_oe;

      unique case (state)
         IDLE: begin
            clk_oe_n  = 1'b0;
            data_oe_n = 1'b0;
            if (tx_start) begin
               state_n    = INHIBIT;
               shreg_n    = {1'b1, ~^tx_data, tx_data};
               bit_cnt_n  = '0;
               timer_n    = '0;
               err_code_n = 2'b00;
               busy_n     = 1'b1;
               clk_oe_n   = 1'b1;
            end
         end
         INHIBIT: begin
            if (timer == INHIBIT_LAST) begin
               state_n   = REQ;
               data_oe_n = 1'b1;
            end else begin
               timer_n = timer + 1'b1;
            end
         end
         REQ: begin
            state_n  = SHIFT;
            clk_oe_n = 1'b0;
            timer_n  = TW'(1);   // watchdog counts cycles since the REQ cycle
         end
         SHIFT: begin
            timer_n = timer + 1'b1;
            if (fe) begin
               data_oe_n = ~shreg[0];
               shreg_n   = {1'b0, shreg[9:1]};
               bit_cnt_n = bit_cnt + 4'd1;
               if (bit_cnt == 4'd9) state_n = ACK;
            end
         end
         ACK: begin
            timer_n = timer + 1'b1;
            if (fe) begin
               state_n = WAIT_IDLE;
               if (data_sync[1]) err_code_n = 2'b01;
            end
         end
         WAIT_IDLE: begin
            if (clk_sync[1] && data_sync[1]) begin
               state_n = IDLE;
               busy_n  = 1'b0;
               if (err_code == 2'b01) error_n = 1'b1;
               else                   done_n  = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase

      // A stalled device aborts the frame regardless of pending edges.
      if ((state == SHIFT || state == ACK) && wd_expired) begin
         state_n    = IDLE;
         clk_oe_n   = 1'b0;
         data_oe_n  = 1'b0;
         err_code_n = 2'b10;
         error_n    = 1'b1;
         busy_n     = 1'b0;
      end
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: an open-drain PS/2 device model plus a transaction-level reference
// that predicts the inhibit/REQ timeline, the captured frame and the completion pulse.
module tb_ps2_host_tx;

   localparam int INH = 10;
   localparam int TO  = 2000;
   localparam int H   = 10;   // device clock half-period in system cycles

   typedef enum int {K_OK, K_NACK, K_TO} kind_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] tx_data;
   logic       tx_start;
   logic       tx_busy, tx_done, tx_error;
   logic [1:0] err_code;
   logic       ps2_clk_oe, ps2_data_oe;
   logic       dev_clk, dev_data;
   logic       ps2_clk_line, ps2_data_line;

   assign ps2_clk_line  = dev_clk & ~ps2_clk_oe;
   assign ps2_data_line = dev_data & ~ps2_data_oe;

   ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
      .clk         (clk),
      .rst         (rst),
      .tx_data     (tx_data),
      .tx_start    (tx_start),
      .tx_busy     (tx_busy),
      .tx_done     (tx_done),
      .tx_error    (tx_error),
      .err_code    (err_code),
      .ps2_clk_i   (ps2_clk_line),
      .ps2_data_i  (ps2_data_line),
      .ps2_clk_oe  (ps2_clk_oe),
      .ps2_data_oe (ps2_data_oe)
   );

   initial forever #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int          checks, errors;
   logic        m_active;
   kind_t       m_kind;
   int          m_acc_cyc;
   int          dev_rel_cyc;
   logic [10:0] dev_bits;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
      end
   endtask

   // Frame as the device must see it: start 0, LSB-first data, odd parity, stop 1.
   function automatic logic [10:0] exp_frame(input logic [7:0] d);
      int ones = 0;
      for (int i = 0; i < 8; i++) ones += int'(d[i]);
      return {1'b1, (ones % 2 == 0), d, 1'b0};
   endfunction

   function automatic logic [1:0] exp_err(input kind_t k);
      return (k == K_OK) ? 2'b00 : (k == K_NACK) ? 2'b01 : 2'b10;
   endfunction

   task automatic monitor_step();
      int k;
      if (m_active) begin
         k = cyc - m_acc_cyc;
         if (k >= 1 && k <= INH)
            check("inhibit", 32'({tx_busy, ps2_clk_oe, ps2_data_oe, err_code}), 32'(5'b11000));
         else if (k == INH + 1)
            check("req", 32'({tx_busy, ps2_clk_oe, ps2_data_oe}), 32'(3'b111));
         else if (k == INH + 2)
            check("start_bit", 32'({tx_busy, ps2_clk_oe, ps2_data_oe}), 32'(3'b101));
         else if (k > INH + 2) begin
            if (tx_done || tx_error) begin
               check("pulse_kind", 32'({tx_done, tx_error}), (m_kind == K_OK) ? 32'(2'b10) : 32'(2'b01));
               check("pulse_err_code", 32'(err_code), 32'(exp_err(m_kind)));
               check("pulse_release", 32'({tx_busy, ps2_clk_oe, ps2_data_oe}), 32'(0));
               if (m_kind == K_TO)
                  check("timeout_cycle", 32'(cyc), 32'(m_acc_cyc + INH + 1 + TO));
               else
                  check("idle_latency", 32'(cyc > dev_rel_cyc && cyc <= dev_rel_cyc + 5), 32'(1));
               m_active = 1'b0;
            end else begin
               check("busy", 32'(tx_busy), 32'(1));
            end
         end
      end else begin
         check("idle", 32'({tx_busy, tx_done, tx_error, ps2_clk_oe, ps2_data_oe}), 32'(0));
      end
   endtask

   // Device: waits for request-to-send, reads the start bit, clocks n_clk cycles sampling on
   // rising edges, and on the 11th clock answers with ACK (data low) or NACK (data left high).
   task automatic dev_run(input int n_clk, input bit ack);
      int w = 0;
      while (!(ps2_clk_line && !ps2_data_line) && w < 100) begin
         @(negedge clk);
         w++;
      end
      check("rts_seen", 32'({ps2_clk_line, ps2_data_line}), 32'(2'b10));
      if (!(ps2_clk_line && !ps2_data_line)) return;
      dev_bits = '0;
      repeat (H) @(negedge clk);
      dev_bits[0] = ps2_data_line;
      for (int i = 1; i <= n_clk && i <= 10; i++) begin
         dev_clk = 1'b0;
         repeat (H) @(negedge clk);
         dev_bits[i] = ps2_data_line;
         dev_clk = 1'b1;
         repeat (H) @(negedge clk);
      end
      if (n_clk >= 11) begin
         if (ack) dev_data = 1'b0;
         repeat (H / 2) @(negedge clk);
         dev_clk = 1'b0;
         repeat (H) @(negedge clk);
         dev_clk = 1'b1;
         if (!ack) dev_rel_cyc = cyc;
         repeat (H / 2) @(negedge clk);
         dev_data = 1'b1;
         if (ack) dev_rel_cyc = cyc;
      end
   endtask

   task automatic spam_busy(input bit en);
      if (en) begin
         for (int j = 0; j < 4; j++) begin
            repeat ($urandom_range(2, 12)) @(negedge clk);
            if (tx_busy) begin
               tx_data  = 8'($urandom);
               tx_start = 1'b1;
               @(negedge clk);
               tx_start = 1'b0;
            end
         end
      end
   endtask

   task automatic start_txn(input logic [7:0] d, input kind_t kind);
      @(negedge clk);
      tx_data     = d;
      tx_start    = 1'b1;
      m_kind      = kind;
      m_acc_cyc   = cyc;
      m_active    = 1'b1;
      dev_rel_cyc = -1000;
      @(negedge clk);
      tx_start = 1'b0;
      tx_data  = 8'($urandom);
   endtask

   task automatic run_txn(input logic [7:0] d, input kind_t kind, input bit spam);
      int w = 0;
      start_txn(d, kind);
      fork
         dev_run((kind == K_TO) ? 5 : 11, kind == K_OK);
         spam_busy(spam);
      join
      while (m_active && w < 3000) begin
         @(negedge clk);
         w++;
      end
      check("txn_complete", 32'(m_active), 32'(0));
      if (kind != K_TO) check("frame", 32'(dev_bits), 32'(exp_frame(d)));
   endtask

   initial begin
      #900_000;
      $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      kind_t kind;
      int    n_to;
      checks   = 0;
      errors   = 0;
      m_active = 1'b0;
      m_kind   = K_OK;
      m_acc_cyc   = 0;
      dev_rel_cyc = -1000;
      dev_bits = '0;
      rst      = 1'b1;
      tx_start = 1'b0;
      tx_data  = 8'h00;
      dev_clk  = 1'b1;
      dev_data = 1'b1;

      repeat (3) @(negedge clk);
      check("reset_state", 32'({tx_busy, tx_done, tx_error, err_code, ps2_clk_oe, ps2_data_oe}), 32'(0));
      rst = 1'b0;

      fork
         forever begin
            @(negedge clk);
            if (!rst) monitor_step();
         end
      join_none

      repeat (5) @(negedge clk);

      run_txn(8'hED, K_OK, 1'b0);
      check("ed_frame", 32'(dev_bits), 32'(11'h7DA));
      check("ed_err_code", 32'(err_code), 32'(0));
      run_txn(8'h01, K_OK, 1'b1);
      check("x01_frame", 32'(dev_bits), 32'(11'h402));
      run_txn(8'hFF, K_OK, 1'b1);
      check("xff_frame", 32'(dev_bits), 32'(11'h7FE));
      run_txn(8'h3C, K_NACK, 1'b0);
      check("nack_err_code", 32'(err_code), 32'(2'b01));
      run_txn(8'h96, K_TO, 1'b0);
      check("timeout_err_code", 32'(err_code), 32'(2'b10));

      // Reset while d3 (0) of 0xA5 is being driven after fe #4.
      start_txn(8'hA5, K_OK);
      dev_run(4, 1'b0);
      check("pre_rst", 32'({tx_busy, ps2_clk_oe, ps2_data_oe}), 32'(3'b101));
      #2 rst = 1'b1;
      #1 check("rst_mid_shift", 32'({tx_busy, ps2_clk_oe, ps2_data_oe}), 32'(0));
      m_active = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (200) @(negedge clk);

      n_to = 0;
      for (int t = 0; t < 16; t++) begin
         int r = $urandom_range(0, 9);
         kind = (r < 6) ? K_OK : (r < 9 || n_to >= 1) ? K_NACK : K_TO;
         if (kind == K_TO) n_to++;
         repeat ($urandom_range(0, 4)) @(negedge clk);
         run_txn(8'($urandom), kind, 1'($urandom_range(0, 1)));
      end

      repeat (20) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
